// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FSM controller sequencing a multicycle MIPS datapath
module multicycle_control #(
    parameter int ILLEGAL_HALT = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 memReady,
    output logic                 pcWrite,
    output logic                 pcWriteCond,
    output logic                 iorD,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 irWrite,
    output logic                 memToReg,
    output logic                 regDst,
    output logic                 regWrite,
    output logic                 aluSrcA,
    output logic [1:0]           aluSrcB,
    output logic [1:0]           aluOp,
    output logic [1:0]           pcSource,
    output logic [3:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t cur, nxt;
    logic   lw_flag, lw_next;
    logic   retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            lw_flag <= 1'b0;
            retired <= '0;
        end else begin
            cur     <= nxt;
            lw_flag <= lw_next;
            if (retire) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

    always_comb begin
        nxt         = cur;
        lw_next     = lw_flag;
        retire      = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        case (cur)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) nxt = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE: nxt = S_EXEC;
                    OP_LW: begin
                        nxt     = S_MEMADR;
                        lw_next = 1'b1;
                    end
                    OP_SW: begin
                        nxt     = S_MEMADR;
                        lw_next = 1'b0;
                    end
                    OP_BEQ:  nxt = S_BRANCH;
                    OP_J:    nxt = S_JUMP;
                    OP_ADDI: nxt = S_ADDIEX;
                    default: begin
                        if (ILLEGAL_HALT != 0) begin
                            nxt = S_HALT;
                        end else begin
                            nxt    = S_FETCH;
                            retire = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                nxt     = lw_flag ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                nxt         = S_FETCH;
                retire      = 1'b1;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                nxt     = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_HALT: nxt = S_HALT;
            // Unused encodings recover to FETCH without retiring anything.
            default: nxt = S_FETCH;
        endcase
    end

endmodule
